fp_norm_round: RTL and testbench

Downstream stage of the single-precision floating add/subtract datapath. It consumes the raw signed-magnitude sum produced by the F_SUB mantissa adder: sign, biased exponent of the larger operand, and an extended mantissa with carry, hidden, guard, round and sticky bits. It normalises iteratively, one bit per cycle, rounds to nearest-even and emits a packed IEEE-754 word. Valid/ready handshakes on both sides; a multi-cycle FSM replaces a combinational leading-zero shifter.

---
 rtl/fp_norm_round.sv | 167 ++++++++++++++++
 tb/tb_fp_norm_round.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalise / round-to-nearest-even stage of the single-precision
// add/subtract datapath. Takes the raw signed-magnitude adder sum and emits a
// packed IEEE-754 word, normalising one bit per cycle.
//   clk, RST (async, active low), EN (global freeze)
//   in_valid/in_ready, in_sign, in_exp[EXP_W-1:0], in_mant[MANT_W-1:0]
//     in_mant = {carry, hidden, frac[FRAC_W-1:0], G, R, S}
//   out_valid/out_ready, out_result = {sign, exp, frac}, out_flags = {ovf, unf, zero}
//   busy: FSM not idle
module fp_norm_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int MANT_W = FRAC_W + 5
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [MANT_W-1:0]         in_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_result,
  output logic [2:0]                out_flags,
  output logic                      busy
);

  localparam int IEXP_W = EXP_W + 2;
  localparam logic [IEXP_W-1:0] EXP_MAX = IEXP_W'((1 << EXP_W) - 1);
  localparam logic [IEXP_W-1:0] EXP_ONE = IEXP_W'(1);

  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, ROUND, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     sign_q, sign_d;
  logic [IEXP_W-1:0]        exp_q, exp_d;
  logic [MANT_W-1:0]        mant_q, mant_d;
  logic                     sub_q, sub_d;
  logic [EXP_W+FRAC_W:0]    out_result_q, out_result_d;
  logic [2:0]               out_flags_q, out_flags_d;

  // Rounding datapath (consumed in ROUND only)
  logic                     rnd_inc;
  logic [FRAC_W+1:0]        rnd_sig;
  logic [IEXP_W-1:0]        rnd_exp;
  logic [FRAC_W-1:0]        rnd_frac;
  logic                     rnd_unf;
  logic [EXP_W+FRAC_W:0]    rnd_result;
  logic [2:0]               rnd_flags;

  assign in_ready   = EN && (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

  always_comb begin
    rnd_inc    = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rnd_sig    = {1'b0, mant_q[MANT_W-2:3]} + {{(FRAC_W+1){1'b0}}, rnd_inc};
    rnd_exp    = exp_q;
    rnd_frac   = rnd_sig[FRAC_W-1:0];
    rnd_unf    = 1'b0;
    rnd_result = '0;
    rnd_flags  = '0;
    if (mant_q == '0) begin
      rnd_flags = 3'b001;
    end else if (exp_q >= EXP_MAX) begin
      rnd_result = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      rnd_flags  = 3'b100;
    end else begin
      if (rnd_sig[FRAC_W+1]) begin
        rnd_exp  = exp_q + EXP_ONE;
        rnd_frac = rnd_sig[FRAC_W:1];
      end else if (sub_q) begin
        // a subnormal that rounds into the hidden bit becomes the smallest normal
        rnd_exp = rnd_sig[FRAC_W] ? EXP_ONE : '0;
        rnd_unf = ~rnd_sig[FRAC_W];
      end
      if (rnd_exp >= EXP_MAX) begin
        rnd_result = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        rnd_flags  = 3'b100;
      end else begin
        rnd_result = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
        rnd_flags  = {1'b0, rnd_unf, 1'b0};
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    mant_d       = mant_q;
    sub_d        = sub_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    if (EN) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_d  = in_sign;
            exp_d   = {2'b00, in_exp};
            mant_d  = in_mant;
            sub_d   = 1'b0;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (mant_q == '0) begin
            sign_d  = 1'b0;
            state_d = ROUND;
          end else if (mant_q[MANT_W-1]) begin
            // carry: shift right once, folding the dropped bit into sticky;
            // the non-overflow case passes through SHIFT (hidden bit now set)
            mant_d  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
            exp_d   = exp_q + EXP_ONE;
            state_d = ((exp_q + EXP_ONE) >= EXP_MAX) ? ROUND : SHIFT;
          end else begin
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (mant_q[MANT_W-2]) begin
            state_d = ROUND;
          end else if (exp_q > EXP_ONE) begin
            mant_d = {mant_q[MANT_W-2:0], 1'b0};
            exp_d  = exp_q - EXP_ONE;
          end else begin
            sub_d   = 1'b1;
            state_d = ROUND;
          end
        end
        ROUND: begin
          out_result_d = rnd_result;
          out_flags_d  = rnd_flags;
          state_d      = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      mant_q       <= '0;
      sub_q        <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      mant_q       <= mant_d;
      sub_q        <= sub_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        RST;
  logic        EN;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  fp_norm_round #(.EXP_W(8), .FRAC_W(23), .MANT_W(28)) dut (
    .clk(clk), .RST(RST), .EN(EN),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic [31:0] res;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Issue one operand, return result, flags and edges from accept to out_valid.
  // Optionally drops EN for stall_len cycles after edge stall_at.
  task automatic do_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                       input int stall_at, input int stall_len,
                       output logic [31:0] res, output logic [2:0] flg, output int lat);
    int w;
    bit seen;
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (stall_at > 0 && lat == stall_at) begin
        EN = 1'b0;
        for (int i = 0; i < stall_len; i++) begin
          @(posedge clk); #1; lat++;
          chk("en_low_no_valid", {31'b0, out_valid}, 32'd0);
        end
        EN = 1'b1;
      end
      if (out_valid) seen = 1;
    end
    if (!seen) lat = -1;
    res = out_result;
    flg = out_flags;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    bit          stale;

    vecs.push_back('{"plain_neg",   1'b1, 8'd128, 28'h6000000, 32'hC0400000, 3'b000, 3});
    vecs.push_back('{"carry",       1'b0, 8'd127, 28'hC000000, 32'h40400000, 3'b000, 3});
    vecs.push_back('{"cancel3",     1'b0, 8'd127, 28'h0800000, 32'h3E000000, 3'b000, 6});
    vecs.push_back('{"zero_pos",    1'b0, 8'd127, 28'h0000000, 32'h00000000, 3'b001, 2});
    vecs.push_back('{"zero_neg",    1'b1, 8'd200, 28'h0000000, 32'h00000000, 3'b001, 2});
    vecs.push_back('{"rnd_up",      1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b000, 3});
    vecs.push_back('{"rnd_tie",     1'b0, 8'd127, 28'h4000004, 32'h3F800000, 3'b000, 3});
    vecs.push_back('{"ovf_carry",   1'b0, 8'd254, 28'hC000000, 32'h7F800000, 3'b100, 2});
    vecs.push_back('{"ovf_round",   1'b1, 8'd254, 28'h7FFFFFC, 32'hFF800000, 3'b100, 3});
    vecs.push_back('{"subnorm",     1'b0, 8'd1,   28'h0400000, 32'h00080000, 3'b010, 3});
    vecs.push_back('{"sub_to_norm", 1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 3'b000, 3});
    vecs.push_back('{"sub_partial", 1'b0, 8'd3,   28'h0100000, 32'h00080000, 3'b010, 5});
    vecs.push_back('{"carry_stky",  1'b0, 8'd127, 28'hC000009, 32'h40400001, 3'b000, 3});
    vecs.push_back('{"norm_min",    1'b0, 8'd2,   28'h2000000, 32'h00800000, 3'b000, 4});

    RST = 1'b0; EN = 1'b1; in_valid = 1'b0; in_sign = 1'b0;
    in_exp = '0; in_mant = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_result",    out_result,         32'd0);
    chk("rst_flags",     {29'b0, out_flags}, 32'd0);
    RST = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);

    foreach (vecs[i]) begin
      do_op(vecs[i].sign, vecs[i].exp, vecs[i].mant, 0, 0, r, f, l);
      chk({vecs[i].name, "_res"},   r, vecs[i].res);
      chk({vecs[i].name, "_flags"}, {29'b0, f}, {29'b0, vecs[i].flags});
      chk({vecs[i].name, "_lat"},   l, vecs[i].lat);
      consume();
    end

    // Backpressure: result must hold while out_ready stays low
    do_op(1'b1, 8'd128, 28'h6000000, 0, 0, r, f, l);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_valid",    {31'b0, out_valid}, 32'd1);
      chk("hold_result",   out_result,         32'hC0400000);
      chk("hold_in_ready", {31'b0, in_ready},  32'd0);
    end
    consume();

    // EN low for 3 cycles mid-SHIFT extends latency by exactly 3
    do_op(1'b0, 8'd127, 28'h0800000, 2, 3, r, f, l);
    chk("stall_res",   r,          32'h3E000000);
    chk("stall_flags", {29'b0, f}, 32'd0);
    chk("stall_lat",   l,          32'd9);
    consume();

    // Reset mid-SHIFT discards the operand
    in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h0000008; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy_before", {31'b0, busy}, 32'd1);
    RST = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_busy",  {31'b0, busy},      32'd0);
    @(negedge clk);
    RST = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    stale = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) stale = 1;
    end
    chk("mid_rst_no_stale", {31'b0, stale}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
